// File: rtl/plic_target_cc_if.sv
// Claim/complete bus between the register interface (master) and the
// PLIC target claim/complete engine (slave).
interface plic_target_cc_if #(
    parameter int ID_BITS = 4
);
    logic               claim_req;
    logic               claim_rdy;
    logic               claim_ack;
    logic [ID_BITS-1:0] claim_id;
    logic               complete_req;
    logic [ID_BITS-1:0] complete_id;

    modport master (
        output claim_req, complete_req, complete_id,
        input  claim_rdy, claim_ack, claim_id
    );

    modport slave (
        input  claim_req, complete_req, complete_id,
        output claim_rdy, claim_ack, claim_id
    );
endinterface

// File: rtl/plic_target_cc.sv
// PLIC target claim/complete engine for one hart context.
// Registers the best enabled pending source above threshold every cycle,
// serves claim reads with a four-state FSM and forwards completions to the
// gateways. Optional in-service tracking: define PLIC_TARGET_INSVC_CHECK_EN
// to forward a completion only for a source that is currently claimed.
//
//   state    | meaning
//   S_IDLE   | ready for a claim request
//   S_ACK    | claim_id valid, claim pulse to the gateway
//   S_BLOCK0 | gateway drops ip, selection refreshes
//   S_BLOCK1 | selection settled, back to IDLE next
module plic_target_cc #(
    parameter int SOURCES    = 8,
    parameter int PRIORITIES = 7
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [SOURCES-1:0]                             ip_i,
    input  logic [SOURCES-1:0]                             ie_i,
    input  logic [SOURCES*$clog2(PRIORITIES+1)-1:0]        prio_i,
    input  logic [$clog2(PRIORITIES+1)-1:0]                threshold_i,
    output logic                                           irq_o,
    output logic [SOURCES-1:0]                             claim_o,
    output logic [SOURCES-1:0]                             complete_o,
    plic_target_cc_if.slave                                bus
);
    localparam int PRIO_BITS = $clog2(PRIORITIES + 1);
    localparam int ID_BITS   = $clog2(SOURCES + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACK    = 2'd1,
        S_BLOCK0 = 2'd2,
        S_BLOCK1 = 2'd3
    } state_t;

    logic [ID_BITS-1:0]   sel_id_d;
    logic [PRIO_BITS-1:0] sel_prio_d;
    logic [ID_BITS-1:0]   best_id_q;
    logic [PRIO_BITS-1:0] best_prio_q;

    state_t               state_q, state_d;
    logic                 claim_rdy_q;
    logic [ID_BITS-1:0]   claim_id_q;
    logic                 capture_d;
    logic                 claim_ack_d;
    logic [SOURCES-1:0]   claim_pulse_d;

    logic [SOURCES-1:0]   cmp_hit_d;
    logic [SOURCES-1:0]   cmp_fwd_d;
    logic [SOURCES-1:0]   complete_q;

    // Priority selection: strict '>' while scanning upward keeps the lowest ID on ties.
    always_comb begin
        sel_id_d   = '0;
        sel_prio_d = '0;
        for (int i = 0; i < SOURCES; i++) begin
            if (ip_i[i] && ie_i[i]
                && (prio_i[i*PRIO_BITS +: PRIO_BITS] > threshold_i)
                && (prio_i[i*PRIO_BITS +: PRIO_BITS] > sel_prio_d)) begin
                sel_prio_d = prio_i[i*PRIO_BITS +: PRIO_BITS];
                sel_id_d   = ID_BITS'(i + 1);
            end
        end
    end

    // Selection register; irq is derived from it so both move on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            best_id_q   <= '0;
            best_prio_q <= '0;
        end else begin
            best_id_q   <= sel_id_d;
            best_prio_q <= sel_prio_d;
        end
    end

    // A winner always has a nonzero priority, so this equals best_id != 0.
    assign irq_o = |best_prio_q;

    // Claim FSM state register, ready flag and captured claim ID.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            claim_rdy_q <= 1'b0;
            claim_id_q  <= '0;
        end else begin
            state_q     <= state_d;
            claim_rdy_q <= (state_d == S_IDLE);
            if (capture_d) begin
                claim_id_q <= best_id_q;
            end
        end
    end

    // Claim FSM next-state and strobes.
    always_comb begin
        state_d       = state_q;
        capture_d     = 1'b0;
        claim_ack_d   = 1'b0;
        claim_pulse_d = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.claim_req && claim_rdy_q) begin
                    capture_d = 1'b1;
                    state_d   = S_ACK;
                end
            end
            S_ACK: begin
                claim_ack_d = 1'b1;
                for (int i = 0; i < SOURCES; i++) begin
                    claim_pulse_d[i] = (claim_id_q == ID_BITS'(i + 1));
                end
                state_d = S_BLOCK0;
            end
            S_BLOCK0: state_d = S_BLOCK1;
            S_BLOCK1: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign bus.claim_rdy = claim_rdy_q;
    assign bus.claim_ack = claim_ack_d;
    assign bus.claim_id  = claim_id_q;
    assign claim_o       = claim_pulse_d;

    // Completion decode; IDs 0 and above SOURCES match no bit.
    always_comb begin
        cmp_hit_d = '0;
        for (int i = 0; i < SOURCES; i++) begin
            cmp_hit_d[i] = bus.complete_req && (bus.complete_id == ID_BITS'(i + 1));
        end
    end

`ifdef PLIC_TARGET_INSVC_CHECK_EN
    logic [SOURCES-1:0] insvc_q;
    logic [SOURCES-1:0] insvc_d;

    // In-service tracking: a claim in the same cycle overrides a completion clear.
    always_comb begin
        cmp_fwd_d = cmp_hit_d & insvc_q;
        insvc_d   = (insvc_q & ~cmp_fwd_d) | claim_pulse_d;
    end

    // In-service register.
    always_ff @(posedge clk) begin
        if (rst) begin
            insvc_q <= '0;
        end else begin
            insvc_q <= insvc_d;
        end
    end
`else
    // Without in-service tracking every in-range completion is forwarded.
    always_comb begin
        cmp_fwd_d = cmp_hit_d;
    end
`endif

    // Complete pulses to the gateways, one cycle after the request.
    always_ff @(posedge clk) begin
        if (rst) begin
            complete_q <= '0;
        end else begin
            complete_q <= cmp_fwd_d;
        end
    end

    assign complete_o = complete_q;

endmodule

// File: tb/tb_plic_target_cc.sv
// Bench for plic_target_cc: directed scenarios plus randomized claim/complete
// traffic checked against a priority-scan reference model.
module tb_plic_target_cc;
    localparam int S  = 8;
    localparam int PB = 3;
    localparam int IB = 4;
`ifdef PLIC_TARGET_INSVC_CHECK_EN
    localparam bit INSVC_EN = 1'b1;
`else
    localparam bit INSVC_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [S-1:0]  ip, ie;
    logic [S*PB-1:0] prio;
    logic [PB-1:0] thr;
    logic          irq;
    logic [S-1:0]  claim, complete;

    plic_target_cc_if #(.ID_BITS(IB)) bus ();

    plic_target_cc #(.SOURCES(S), .PRIORITIES(7)) dut (
        .clk         (clk),
        .rst         (rst),
        .ip_i        (ip),
        .ie_i        (ie),
        .prio_i      (prio),
        .threshold_i (thr),
        .irq_o       (irq),
        .claim_o     (claim),
        .complete_o  (complete),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit insvc_m [1:S];

    // Reference: scan priorities from the top down, IDs from the bottom up.
    function automatic int model_best();
        for (int p = 7; p > int'(thr); p--)
            for (int id = 1; id <= S; id++)
                if (ip[id-1] && ie[id-1] && int'(prio[(id-1)*PB +: PB]) == p)
                    return id;
        return 0;
    endfunction

    function automatic logic [S-1:0] onehot(input int id);
        logic [S-1:0] v;
        v = '0;
        if (id >= 1 && id <= S) v[id-1] = 1'b1;
        return v;
    endfunction

    function automatic logic [S-1:0] exp_complete(input int id);
        if (id >= 1 && id <= S && (!INSVC_EN || insvc_m[id])) return onehot(id);
        return '0;
    endfunction

    task automatic set_prio(input int id, input int p);
        prio[(id-1)*PB +: PB] = PB'(p);
    endtask

    task automatic clear_model();
        for (int i = 1; i <= S; i++) insvc_m[i] = 1'b0;
    endtask

    // Issue one claim read; the bench acts as gateway and drops ip of the expected ID.
    task automatic do_claim(input int exp_id, output bit got, output int id, output logic [S-1:0] pulse);
        got = 1'b0; id = -1; pulse = '0;
        bus.claim_req = 1'b1;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (bus.claim_ack) begin
                got = 1'b1; id = int'(bus.claim_id); pulse = claim;
            end
        end
        bus.claim_req = 1'b0;
        if (exp_id != 0) begin
            ip[exp_id-1] = 1'b0;
            insvc_m[exp_id] = 1'b1;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic do_complete(input int id, output logic [S-1:0] p1, output logic [S-1:0] p2);
        bus.complete_req = 1'b1;
        bus.complete_id  = IB'(id);
        @(negedge clk);
        p1 = complete;
        bus.complete_req = 1'b0;
        bus.complete_id  = '0;
        @(negedge clk);
        p2 = complete;
    endtask

    task automatic test_reset();
        rst = 1'b1; ip = '0; ie = '0; prio = '0; thr = '0;
        bus.claim_req = 1'b0; bus.complete_req = 1'b0; bus.complete_id = '0;
        clear_model();
        repeat (2) @(negedge clk);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
        checks++; if (bus.claim_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got=%b exp=0", bus.claim_rdy); end
        checks++; if (bus.claim_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", bus.claim_ack); end
        checks++; if (bus.claim_id !== '0) begin errors++; $display("FAIL reset_id got=%0d exp=0", bus.claim_id); end
        checks++; if (claim !== '0 || complete !== '0) begin errors++; $display("FAIL reset_pulses claim=%h complete=%h exp=00/00", claim, complete); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.claim_rdy !== 1'b1) begin errors++; $display("FAIL release_rdy got=%b exp=1", bus.claim_rdy); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL release_irq got=%b exp=0", irq); end
    endtask

    task automatic test_basic();
        bit got; int id; logic [S-1:0] pulse;
        ie = 8'hFF; prio = '0; set_prio(3, 2); set_prio(5, 5); thr = 3'd1;
        ip = 8'h14;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL basic_irq_latency got=%b exp=0", irq); end
        @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL basic_irq got=%b exp=1", irq); end
        do_claim(model_best(), got, id, pulse);
        checks++; if (!got || id !== 5) begin errors++; $display("FAIL basic_claim_id got=%0d ack=%b exp=5", id, got); end
        checks++; if (pulse !== 8'h10) begin errors++; $display("FAIL basic_claim_pulse got=%h exp=10", pulse); end
        checks++; if (irq !== (model_best() != 0)) begin errors++; $display("FAIL basic_irq_after got=%b exp=%b", irq, model_best() != 0); end
    endtask

    task automatic test_tie();
        bit got; int id; int exp; logic [S-1:0] pulse;
        prio = '0; set_prio(2, 4); set_prio(6, 4); thr = 3'd0; ip = 8'h22;
        @(negedge clk);
        exp = model_best();
        do_claim(exp, got, id, pulse);
        checks++; if (!got || id !== 2) begin errors++; $display("FAIL tie_id got=%0d exp=2", id); end
        checks++; if (pulse !== 8'h02) begin errors++; $display("FAIL tie_pulse got=%h exp=02", pulse); end
        ip = 8'h22; thr = 3'd4;
        @(negedge clk);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL thr_irq got=%b exp=0", irq); end
        do_claim(model_best(), got, id, pulse);
        checks++; if (!got || id !== 0) begin errors++; $display("FAIL thr_id got=%0d ack=%b exp=0", id, got); end
        checks++; if (pulse !== 8'h00) begin errors++; $display("FAIL thr_pulse got=%h exp=00", pulse); end
    endtask

    task automatic test_complete();
        logic [S-1:0] p1, p2, e;
        int ids [5] = '{5, 0, 9, 15, 3};
        foreach (ids[k]) begin
            e = exp_complete(ids[k]);
            do_complete(ids[k], p1, p2);
            checks++; if (p1 !== e) begin errors++; $display("FAIL complete_%0d got=%h exp=%h", ids[k], p1, e); end
            checks++; if (p2 !== '0) begin errors++; $display("FAIL complete_%0d_width got=%h exp=00", ids[k], p2); end
            if (e != '0) insvc_m[ids[k]] = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        int acks [$];
        int exp;
        ie = 8'hFF; thr = 3'd0;
        for (int i = 1; i <= S; i++) set_prio(i, $urandom_range(1, 7));
        ip = 8'h49 | 8'($urandom);
        @(negedge clk);
        bus.claim_req = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (bus.claim_ack) begin
                acks.push_back(c);
                exp = model_best();
                checks++; if (int'(bus.claim_id) !== exp || claim !== onehot(exp)) begin
                    errors++; $display("FAIL b2b_claim got=%0d/%h exp=%0d/%h", bus.claim_id, claim, exp, onehot(exp));
                end
                if (exp != 0) begin ip[exp-1] = 1'b0; insvc_m[exp] = 1'b1; end
            end
        end
        bus.claim_req = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (acks.size() != 4 || acks[0] != 0) begin errors++; $display("FAIL b2b_count got=%0d exp=4", acks.size()); end
        for (int k = 1; k < acks.size(); k++) begin
            checks++; if (acks[k] - acks[k-1] != 4) begin errors++; $display("FAIL b2b_spacing got=%0d exp=4", acks[k] - acks[k-1]); end
        end
    endtask

    task automatic test_random();
        bit got; int id; int exp; int cid; logic [S-1:0] pulse, p1, p2, e;
        for (int n = 0; n < 25; n++) begin
            ip = 8'($urandom); ie = 8'($urandom); prio = 24'($urandom); thr = 3'($urandom_range(0, 4));
            @(negedge clk);
            exp = model_best();
            checks++; if (irq !== (exp != 0)) begin errors++; $display("FAIL rnd_irq n=%0d got=%b exp=%b", n, irq, exp != 0); end
            do_claim(exp, got, id, pulse);
            checks++; if (!got || id !== exp || pulse !== onehot(exp)) begin
                errors++; $display("FAIL rnd_claim n=%0d got=%0d/%h exp=%0d/%h", n, id, pulse, exp, onehot(exp));
            end
            cid = ($urandom_range(0, 1) == 1) ? exp : $urandom_range(0, 10);
            e = exp_complete(cid);
            do_complete(cid, p1, p2);
            checks++; if (p1 !== e || p2 !== '0) begin
                errors++; $display("FAIL rnd_complete n=%0d id=%0d got=%h/%h exp=%h/00", n, cid, p1, p2, e);
            end
            if (e != '0) insvc_m[cid] = 1'b0;
        end
    endtask

    task automatic test_midop_reset();
        logic [S-1:0] p1, p2, e;
        ie = 8'hFF; prio = '0; set_prio(4, 6); thr = 3'd0; ip = 8'h08;
        @(negedge clk);
        bus.claim_req = 1'b1;
        @(negedge clk);
        checks++; if (bus.claim_ack !== 1'b1 || claim !== 8'h08) begin errors++; $display("FAIL midop_ack got=%b/%h exp=1/08", bus.claim_ack, claim); end
        rst = 1'b1; bus.claim_req = 1'b0;
        @(negedge clk);
        checks++; if (bus.claim_ack !== 1'b0 || claim !== '0 || irq !== 1'b0 || bus.claim_rdy !== 1'b0) begin
            errors++; $display("FAIL midop_reset ack=%b claim=%h irq=%b rdy=%b exp=0/00/0/0", bus.claim_ack, claim, irq, bus.claim_rdy);
        end
        rst = 1'b0; ip = '0;
        clear_model();
        @(negedge clk);
        e = exp_complete(4);
        do_complete(4, p1, p2);
        checks++; if (p1 !== e) begin errors++; $display("FAIL midop_insvc got=%h exp=%h", p1, e); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_complete();
        test_back_to_back();
        test_random();
        test_midop_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
